// File: rtl/grostl_shift_bytes_buf_pkg.sv
// grostl_pkg: shared types and constants for the masked Groestl ShiftBytes
// column buffer.
//   col_t    : one 8-byte state column, byte index = row
//   bank_t   : one full 512-bit state, column-major (bank[col][row])
//   SIGMA_P  : per-row column offsets for the P permutation
//   SIGMA_Q  : per-row column offsets for the Q permutation
package grostl_pkg;

    localparam int NCOLS = 8;

    typedef logic [0:7][7:0]             col_t;
    typedef logic [0:NCOLS-1][0:7][7:0]  bank_t;
    typedef logic [0:7][2:0]             sigma_t;

    localparam sigma_t SIGMA_P = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam sigma_t SIGMA_Q = {3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};

endpackage

// File: rtl/grostl_shift_bytes_buf_if.sv
// Stream interface of the ShiftBytes buffer: input column channel from
// SubBytes and output column channel towards the next round stage.
//   slave  : the buffer (consumes in_*, produces out_*)
//   master : the environment (produces in_*, consumes out_*)
interface grostl_shift_bytes_buf_if;
    import grostl_pkg::*;

    logic in_valid;
    logic in_ready;
    col_t in_data;
    col_t in_mask;
    logic in_q;
    logic out_valid;
    logic out_ready;
    col_t out_data;
    col_t out_mask;
    logic out_q;

    modport slave (
        input  in_valid, in_data, in_mask, in_q, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_q
    );

    modport master (
        output in_valid, in_data, in_mask, in_q, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_q
    );

endinterface

// File: rtl/grostl_shift_bytes_buf_col_mux.sv
// grostl_shift_col_mux: combinational ShiftBytes column selector.
// Output row i is taken from column (i_col + sigma_i) mod 8 of i_bank,
// with sigma chosen by i_q (0 = P, 1 = Q). One instance per share, so data
// and mask are never routed through common logic.
//   i_bank : full state bank
//   i_col  : output column index
//   i_q    : permutation select
//   o_col  : shifted column
module grostl_shift_col_mux
    import grostl_pkg::*;
(
    input  bank_t      i_bank,
    input  logic [2:0] i_col,
    input  logic       i_q,
    output col_t       o_col
);

    for (genvar i = 0; i < 8; i++) begin : g_row
        logic [2:0] w_idx;
        // 3-bit add wraps naturally to give the mod-8 column index
        assign w_idx    = i_col + (i_q ? SIGMA_Q[i] : SIGMA_P[i]);
        assign o_col[i] = i_bank[w_idx][i];
    end

endmodule

// File: rtl/grostl_shift_bytes_buf.sv
// grostl_shift_bytes_buf: ping-pong column buffer performing masked Groestl
// ShiftBytes. Eight columns (data + mask shares) are written into one bank
// while the other bank is read out permuted, one column per cycle.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous flush of both banks and all pointers
//   bus    : stream interface (slave side)
module grostl_shift_bytes_buf
    import grostl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    grostl_shift_bytes_buf_if.slave    bus
);

    bank_t      r_data [0:1];
    bank_t      r_mask [0:1];
    logic [1:0] r_q;
    logic [1:0] r_full;
    logic       r_wr_bank;
    logic [2:0] r_wr_col;
    logic       r_rd_bank;
    logic [2:0] r_rd_col;

    logic       w_wr_fire;
    logic       w_rd_fire;
    col_t       w_out_data;
    col_t       w_out_mask;

    assign w_wr_fire = bus.in_valid & ~r_full[r_wr_bank];
    assign w_rd_fire = r_full[r_rd_bank] & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '{default: '0};
            r_mask    <= '{default: '0};
            r_q       <= '0;
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_wr_col  <= '0;
            r_rd_bank <= 1'b0;
            r_rd_col  <= '0;
        end else if (clear) begin
            // storage is left as is; the cleared full flags make it invisible
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_wr_col  <= '0;
            r_rd_bank <= 1'b0;
            r_rd_col  <= '0;
        end else begin
            // full-flag gating keeps the write and read banks distinct here
            if (w_wr_fire) begin
                r_data[r_wr_bank][r_wr_col] <= bus.in_data;
                r_mask[r_wr_bank][r_wr_col] <= bus.in_mask;
                if (r_wr_col == 3'd0) begin
                    r_q[r_wr_bank] <= bus.in_q;
                end
                r_wr_col <= r_wr_col + 3'd1;
                if (r_wr_col == 3'd7) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                end
            end
            if (w_rd_fire) begin
                r_rd_col <= r_rd_col + 3'd1;
                if (r_rd_col == 3'd7) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                end
            end
        end
    end

    grostl_shift_col_mux u_mux_data (
        .i_bank (r_data[r_rd_bank]),
        .i_col  (r_rd_col),
        .i_q    (r_q[r_rd_bank]),
        .o_col  (w_out_data)
    );

    grostl_shift_col_mux u_mux_mask (
        .i_bank (r_mask[r_rd_bank]),
        .i_col  (r_rd_col),
        .i_q    (r_q[r_rd_bank]),
        .o_col  (w_out_mask)
    );

    assign bus.in_ready  = ~r_full[r_wr_bank];
    assign bus.out_valid = r_full[r_rd_bank];
    assign bus.out_data  = w_out_data;
    assign bus.out_mask  = w_out_mask;
    assign bus.out_q     = r_q[r_rd_bank];

endmodule
